half_word_feeder: RTL and testbench



---
 rtl/half_word_feeder_pkg.sv | 19 +
 rtl/half_word_feeder_fsm.sv | 145 ++++++++++++++
 rtl/half_word_feeder.sv | 114 +++++++++++
 tb/tb_half_word_feeder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/half_word_feeder_pkg.sv
// Shared types and constants for the half-word feeder and the zero-count
// stage that consumes its 16-bit output stream.
package half_word_feeder_pkg;

  localparam int HALF_W     = 16;
  localparam int WORD_W     = 32;
  localparam int DEF_ADDR_W = 7;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_EMIT_LO,
    ST_EMIT_HI,
    ST_FIN
  } fsm_state_e;

endpackage

// File: rtl/half_word_feeder_fsm.sv
// Control for the half-word feeder: state register, read-address counter and
// remaining-word counter. Optional prefetch of the next word while the
// current one is being emitted: HALF_WORD_FEEDER_PREFETCH_EN.
//
// rem_q counts the words still to be emitted *after* the word currently held
// in the top-level word register, so out_last is simply rem_q == 0 in EMIT_HI.
module half_word_feeder_fsm
  import half_word_feeder_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  word_count_i,
  input  logic              out_ready_i,
`ifdef HALF_WORD_FEEDER_PREFETCH_EN
  output logic              pf_ld_o,
  output logic              pf_use_o,
`endif
  output fsm_state_e        state_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              word_ld_o,
  output logic              rem_zero_o
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  fsm_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;

`ifdef HALF_WORD_FEEDER_PREFETCH_EN
  // pf_iss_q: next word already requested for the word now in EMIT_LO/HI.
  // pf_ld_q:  read data arrives this cycle and goes to the prefetch register.
  logic pf_iss_q, pf_iss_d;
  logic pf_ld_q, pf_ld_d;
  logic pf_use;

  // Prefetch bookkeeping; reset drops any read still in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pf_iss_q <= 1'b0;
      pf_ld_q  <= 1'b0;
    end else begin
      pf_iss_q <= pf_iss_d;
      pf_ld_q  <= pf_ld_d;
    end
  end

  assign pf_ld_o  = pf_ld_q;
  assign pf_use_o = pf_use;
`endif

  // State, address and remaining-count registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state, counter updates and read strobe.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    rd_en_o   = 1'b0;
    word_ld_o = 1'b0;
`ifdef HALF_WORD_FEEDER_PREFETCH_EN
    pf_iss_d  = pf_iss_q;
    pf_ld_d   = 1'b0;
    pf_use    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (word_count_i != '0) begin
            addr_d  = base_addr_i;
            rem_d   = word_count_i;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_FETCH: begin
        rd_en_o = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // rem_q >= 1 here: FETCH is only entered with words outstanding.
        word_ld_o = 1'b1;
        addr_d    = addr_q + ADDR_ONE;
        rem_d     = rem_q - CNT_ONE;
        state_d   = ST_EMIT_LO;
      end
      ST_EMIT_LO: begin
`ifdef HALF_WORD_FEEDER_PREFETCH_EN
        // First LO cycle: request the next word so it is ready for the
        // HI handshake even with out_ready held high.
        if (!pf_iss_q && rem_q != '0) begin
          rd_en_o  = 1'b1;
          addr_d   = addr_q + ADDR_ONE;
          pf_iss_d = 1'b1;
          pf_ld_d  = 1'b1;
        end
`endif
        if (out_ready_i) state_d = ST_EMIT_HI;
      end
      ST_EMIT_HI: begin
        if (out_ready_i) begin
          if (rem_q == '0) begin
            state_d = ST_FIN;
          end else begin
`ifdef HALF_WORD_FEEDER_PREFETCH_EN
            pf_use   = 1'b1;
            pf_iss_d = 1'b0;
            rem_d    = rem_q - CNT_ONE;
            state_d  = ST_EMIT_LO;
`else
            state_d  = ST_FETCH;
`endif
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign state_o    = state_q;
  assign rd_addr_o  = addr_q;
  assign rem_zero_o = (rem_q == '0);

endmodule

// File: rtl/half_word_feeder.sv
// Streams a run of 32-bit memory words as 16-bit halves (low first) over a
// valid/ready interface. Optional next-word prefetch for 2 cycles/word:
// HALF_WORD_FEEDER_PREFETCH_EN.
module half_word_feeder
  import half_word_feeder_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              CLK,
  input  logic              RST_X,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [WORD_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HALF_W-1:0] out_data,
  output logic              out_hi,
  output logic              out_last
);

  fsm_state_e        state;
  logic              rem_zero;
  logic              word_ld;
  logic [WORD_W-1:0] word_q, word_d;

`ifdef HALF_WORD_FEEDER_PREFETCH_EN
  logic              pf_ld;
  logic              pf_use;
  logic [WORD_W-1:0] pf_q;
`endif

  half_word_feeder_fsm #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_fsm (
    .clk_i        (CLK),
    .rst_ni       (RST_X),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .word_count_i (word_count),
    .out_ready_i  (out_ready),
`ifdef HALF_WORD_FEEDER_PREFETCH_EN
    .pf_ld_o      (pf_ld),
    .pf_use_o     (pf_use),
`endif
    .state_o      (state),
    .rd_en_o      (mem_rd_en),
    .rd_addr_o    (mem_rd_addr),
    .word_ld_o    (word_ld),
    .rem_zero_o   (rem_zero)
  );

`ifdef HALF_WORD_FEEDER_PREFETCH_EN
  // Prefetch register: holds the next word until the current HI half is taken.
  always_ff @(posedge CLK) begin
    if (!RST_X)     pf_q <= '0;
    else if (pf_ld) pf_q <= mem_rd_data;
  end

  // Word source: fresh read in WAIT, else the prefetched word; if the
  // prefetch returns in the same cycle as the HI handshake, bypass it.
  always_comb begin
    word_d = word_q;
    if (word_ld)     word_d = mem_rd_data;
    else if (pf_use) word_d = pf_ld ? mem_rd_data : pf_q;
  end
`else
  // Word source: read data returned during WAIT.
  always_comb begin
    word_d = word_q;
    if (word_ld) word_d = mem_rd_data;
  end
`endif

  // Word register; only changes between words, so halves stay stable on stall.
  always_ff @(posedge CLK) begin
    if (!RST_X) word_q <= '0;
    else        word_q <= word_d;
  end

  // Status and stream outputs decoded from state only (no ready->valid path).
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    out_valid = 1'b0;
    out_hi    = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    case (state)
      ST_FETCH, ST_WAIT: busy = 1'b1;
      ST_EMIT_LO: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = word_q[HALF_W-1:0];
      end
      ST_EMIT_HI: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_hi    = 1'b1;
        out_last  = rem_zero;
        out_data  = word_q[WORD_W-1:HALF_W];
      end
      ST_FIN:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_half_word_feeder.sv
// Self-checking bench for half_word_feeder. Build with
// HALF_WORD_FEEDER_PREFETCH_EN defined to exercise the prefetch variant.
module tb_half_word_feeder;
  import half_word_feeder_pkg::*;

  localparam int AW    = DEF_ADDR_W;
  localparam int CW    = DEF_CNT_W;
  localparam int DEPTH = 1 << AW;
`ifdef HALF_WORD_FEEDER_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] d;
    logic        hi;
    logic        last;
  } half_t;

  typedef struct {
    int base;
    int cnt;
    int rmode;      // 0: ready=1, 1: random ready, 2: 5-cycle stall per half
    bit poke;       // pulse start mid-run
    int exp_reads;
    int exp_halves;
  } vec_t;

  logic          CLK = 1'b0;
  logic          RST_X, start, busy, done, mem_rd_en, out_valid, out_ready, out_hi, out_last;
  logic [AW-1:0] base_addr, mem_rd_addr;
  logic [CW-1:0] word_count;
  logic [31:0]   mem_rd_data;
  logic [15:0]   out_data;
  logic [31:0]   mem [DEPTH];

  int errors = 0;
  int checks = 0;

  half_word_feeder #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .CLK         (CLK),
    .RST_X       (RST_X),
    .start       (start),
    .base_addr   (base_addr),
    .word_count  (word_count),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_hi      (out_hi),
    .out_last    (out_last)
  );

  always #5 CLK = ~CLK;

  // Word memory: data one cycle after the strobe, junk otherwise.
  always @(posedge CLK) mem_rd_data <= mem_rd_en ? mem[mem_rd_addr] : $urandom;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic half_t mk(input logic [15:0] d, input logic hi, input logic last);
    half_t h;
    h.d = d; h.hi = hi; h.last = last;
    return h;
  endfunction

  // Cycle (counted from the start edge) at which done is high with ready=1.
  function automatic int exp_done(input int n);
    if (n == 0) return 1;
    return PF ? 2*n + 3 : 4*n + 1;
  endfunction

  task automatic run(input int base, input int cnt, input int rmode, input bit poke,
                     input int exp_reads, input int exp_halves);
    half_t       exp_q[$];
    int          ra_q[$];
    half_t       prev;
    logic [63:0] eh, ea;
    int          t, n_rd, n_hs, first_v, last_hs, done_t, stall, budget, a;
    bit          prev_stall, r;
    n_rd = 0; n_hs = 0; first_v = -1; last_hs = -1; done_t = -1; stall = 0;
    prev_stall = 1'b0; prev = '0; budget = 12*cnt + 40;
    // Reference: word i of the run lives at (base+i) mod depth, low half first.
    for (int i = 0; i < cnt; i++) begin
      a = (base + i) % DEPTH;
      ra_q.push_back(a);
      exp_q.push_back(mk(mem[a][15:0], 1'b0, 1'b0));
      exp_q.push_back(mk(mem[a][31:16], 1'b1, i == cnt - 1));
    end
    start = 1'b1; base_addr = AW'(base); word_count = CW'(cnt);
    t = 0;
    while (done_t < 0 && t < budget) begin
      @(negedge CLK);
      t++;
      start      = poke && t == 6 && busy;
      base_addr  = AW'($urandom);
      word_count = CW'($urandom);
      if (t == 1) chk("busy_after_start", busy, cnt != 0);
      if (mem_rd_en) begin
        n_rd++;
        ea = '1;
        if (ra_q.size() > 0) ea = 64'(ra_q.pop_front());
        chk("read_addr", 64'(mem_rd_addr), ea);
      end
      if (prev_stall) chk("stall_hold", {out_valid, out_data, out_hi, out_last}, {1'b1, prev});
      if (out_valid && first_v < 0) first_v = t;
      case (rmode)
        0:       r = 1'b1;
        1:       r = ($urandom % 4) != 0;
        default: begin
          if (out_valid && stall < 5) begin r = 1'b0; stall++; end
          else r = 1'b1;
        end
      endcase
      out_ready = r;
      if (out_valid && r) begin
        n_hs++; last_hs = t; stall = 0;
        eh = '1;
        if (exp_q.size() > 0) eh = 64'(exp_q.pop_front());
        chk("half", 64'({out_data, out_hi, out_last}), eh);
      end
      prev_stall = out_valid && !r;
      prev = {out_data, out_hi, out_last};
      if (done) begin
        done_t = t;
        chk("busy_low_at_done", busy, 0);
        chk("model_drained", exp_q.size(), 0);
      end
    end
    chk("done_seen", done_t >= 0, 1);
    chk("read_count", n_rd, exp_reads);
    chk("half_count", n_hs, exp_halves);
    if (cnt > 0) chk("first_valid_cycle", first_v, 3);
    if (rmode == 0) begin
      chk("done_cycle", done_t, exp_done(cnt));
      if (cnt > 0) chk("stream_span", last_hs - first_v + 1, PF ? 2*cnt : 4*cnt - 2);
    end
    @(negedge CLK);
    start = 1'b0;
    chk("done_one_cycle", {done, busy}, 0);
    out_ready = 1'b1;
  endtask

  initial begin
    vec_t vt[8];
    int   hc, cnt;
    bit   got, seen;
    RST_X = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; out_ready = 1'b1;
    foreach (mem[i]) mem[i] = $urandom;
    repeat (2) @(negedge CLK);
    chk("reset_outputs",
        {busy, done, mem_rd_en, out_valid, out_hi, out_last, mem_rd_addr, out_data}, 0);
    RST_X = 1'b1;
    @(negedge CLK);

    mem[5] = 32'hA5A5_0F0F;
    vt[0] = '{5,   1,   0, 1'b0, 1,   2};    // single word
    vt[1] = '{0,   0,   0, 1'b0, 0,   0};    // zero count
    vt[2] = '{126, 3,   0, 1'b0, 3,   6};    // address wrap
    vt[3] = '{20,  2,   2, 1'b0, 2,   4};    // 5-cycle backpressure per half
    vt[4] = '{40,  4,   0, 1'b1, 4,   8};    // start while busy is ignored
    vt[5] = '{60,  8,   0, 1'b0, 8,   16};   // sustained rate
    vt[6] = '{100, 128, 1, 1'b0, 128, 256};  // full-depth run, random ready
    vt[7] = '{127, 1,   1, 1'b0, 1,   2};    // last address
    foreach (vt[i])
      run(vt[i].base, vt[i].cnt, vt[i].rmode, vt[i].poke, vt[i].exp_reads, vt[i].exp_halves);

    repeat (12) begin
      foreach (mem[i]) mem[i] = $urandom;
      cnt = (($urandom % 6) == 0) ? 0 : int'($urandom_range(1, 20));
      run(int'($urandom % DEPTH), cnt, int'($urandom_range(0, 2)),
          cnt >= 3 && ($urandom % 2) == 1, cnt, 2*cnt);
    end

    // Reset in EMIT_HI of word 2 of 4: run abandoned, no done.
    start = 1'b1; base_addr = 7'd10; word_count = 8'd4; out_ready = 1'b1;
    hc = 0; got = 1'b0;
    for (int t = 1; t <= 60 && !got; t++) begin
      @(negedge CLK);
      start = 1'b0;
      if (out_valid && out_hi) begin
        hc++;
        if (hc == 2) begin RST_X = 1'b0; got = 1'b1; end
      end
    end
    chk("reached_word2_hi", got, 1);
    @(negedge CLK);
    chk("mid_run_reset_outputs",
        {busy, done, mem_rd_en, out_valid, out_hi, out_last, mem_rd_addr, out_data}, 0);
    RST_X = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge CLK);
      if (done || out_valid || mem_rd_en || busy) seen = 1'b1;
    end
    chk("quiet_after_reset", seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
